// File: rtl/gray_updown_counter_if.sv
// Bundles the control and result signals of gray_updown_counter; the master
// drives the count controls and observes the registered results.
interface gray_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             wrap;

  modport master (output enable, up, load, load_gray, input gray_out, bin_out, wrap);
  modport slave  (input enable, up, load, load_gray, output gray_out, bin_out, wrap);
endinterface

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter with Gray-value load and wrap/saturate limits. Binary
// and Gray results are registered from the same next value, so they never skew.
module gray_updown_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  gray_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;
  logic [WIDTH-1:0] bin_nxt_s;
  logic             wrap_nxt_s;

  // Next binary value and wrap pulse; load beats enable, limits wrap or hold.
  always_comb begin
    bin_nxt_s  = bin_r;
    wrap_nxt_s = 1'b0;
    if (bus.load) begin
      bin_nxt_s = gray_to_bin(bus.load_gray);
    end else if (bus.enable) begin
      if (bus.up) begin
        if (bin_r == MAX_C) begin
          if (SATURATE) begin
            bin_nxt_s = bin_r;
          end else begin
            bin_nxt_s  = ZERO_C;
            wrap_nxt_s = 1'b1;
          end
        end else begin
          bin_nxt_s = bin_r + ONE_C;
        end
      end else begin
        if (bin_r == ZERO_C) begin
          if (SATURATE) begin
            bin_nxt_s = bin_r;
          end else begin
            bin_nxt_s  = MAX_C;
            wrap_nxt_s = 1'b1;
          end
        end else begin
          bin_nxt_s = bin_r - ONE_C;
        end
      end
    end else begin
      bin_nxt_s = bin_r;
    end
  end

  // State and output registers; the Gray flop feeds gray_out directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r  <= ZERO_C;
      gray_r <= ZERO_C;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= bin_nxt_s;
      gray_r <= bin_to_gray(bin_nxt_s);
      wrap_r <= wrap_nxt_s;
    end
  end

  assign bus.bin_out  = bin_r;
  assign bus.gray_out = gray_r;
  assign bus.wrap     = wrap_r;

endmodule
